// File: rtl/key_note_select.sv
// Key front end: 2-flop sync, per-key debounce, highest-key select and note FSM.
// Optional release tail enabled by defining KEY_RELEASE_HOLD_EN.
module key_note_select #(
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned DB_W        = 19,
  parameter int unsigned HOLD_CYCLES = 12500000,
  parameter int unsigned HOLD_W      = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  keys,
  output logic [7:0]  keys_db,
  output logic [24:0] half_period,
  output logic [2:0]  note_idx,
  output logic        note_gate,
  output logic        note_start
);

  localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StRelease} state_e;

  state_e            state_q;
  logic [7:0]        sync1_q, sync2_q;
  logic [DB_W-1:0]   db_cnt_q [8];
  logic [2:0]        sel;
  logic              any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
    end
  end

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_db <= '0;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2_q[i] == keys_db[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          keys_db[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Highest pitch wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < 8; i++) begin
      if (keys_db[i]) sel = 3'(i);
    end
  end

  assign any = |keys_db;

  // floor(25 MHz / f) for a 50 MHz clock.
  function automatic logic [24:0] half_period_of(input logic [2:0] idx);
    logic [24:0] hp;
    unique case (idx)
      3'd0: hp = 25'd47778;
      3'd1: hp = 25'd42565;
      3'd2: hp = 25'd37921;
      3'd3: hp = 25'd35793;
      3'd4: hp = 25'd31888;
      3'd5: hp = 25'd28409;
      3'd6: hp = 25'd25309;
      3'd7: hp = 25'd23889;
    endcase
    return hp;
  endfunction

`ifdef KEY_RELEASE_HOLD_EN
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_CYCLES - 1);
  logic [HOLD_W-1:0] hold_cnt_q;
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^{HOLD_CYCLES, HOLD_W};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      half_period <= '0;
      note_idx    <= '0;
      note_gate   <= 1'b0;
      note_start  <= 1'b0;
`ifdef KEY_RELEASE_HOLD_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      note_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any) begin
            note_idx    <= sel;
            half_period <= half_period_of(sel);
            note_gate   <= 1'b1;
            note_start  <= 1'b1;
            state_q     <= StPlay;
          end
        end
        StPlay: begin
          if (!any) begin
`ifdef KEY_RELEASE_HOLD_EN
            hold_cnt_q <= '0;
            state_q    <= StRelease;
`else
            note_gate  <= 1'b0;
            state_q    <= StIdle;
`endif
          end else if (sel != note_idx) begin
            note_idx    <= sel;
            half_period <= half_period_of(sel);
            note_start  <= 1'b1;
          end
        end
`ifdef KEY_RELEASE_HOLD_EN
        StRelease: begin
          // A new press beats tail expiry in the same cycle.
          if (any) begin
            note_idx    <= sel;
            half_period <= half_period_of(sel);
            note_start  <= 1'b1;
            hold_cnt_q  <= '0;
            state_q     <= StPlay;
          end else if (hold_cnt_q == HoldLast) begin
            hold_cnt_q <= '0;
            note_gate  <= 1'b0;
            state_q    <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          note_gate <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_note_select.sv
// Randomised + directed bench for key_note_select against a behavioural model.
module tb_key_note_select;

  localparam int DB   = 16;
  localparam int HOLD = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  keys;
  logic [7:0]  keys_db;
  logic [24:0] half_period;
  logic [2:0]  note_idx;
  logic        note_gate;
  logic        note_start;

  always #10 clk = ~clk;

  key_note_select #(
    .DB_CYCLES  (DB),
    .DB_W       (5),
    .HOLD_CYCLES(HOLD),
    .HOLD_W     (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keys       (keys),
    .keys_db    (keys_db),
    .half_period(half_period),
    .note_idx   (note_idx),
    .note_gate  (note_gate),
    .note_start (note_start)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: raw key history, accepted levels, and note state.
  int         hp_tab [8] = '{47778, 42565, 37921, 35793, 31888, 28409, 25309, 23889};
  logic [7:0] hist [17];
  logic [7:0] m_db = '0;
  logic       m_gate = 1'b0, m_start = 1'b0, m_tail_on = 1'b0;
  logic [2:0] m_idx = '0;
  int         m_hp = 0, m_tail_left = 0;

  // Observation counters over DUT outputs (actuals only).
  int starts = 0, gate_low = 0;

  task automatic model_step();
    logic [7:0] new_db;
    logic [2:0] sel;
    logic       all_diff;
    if (reset) begin
      for (int j = 0; j < 17; j++) hist[j] = '0;
      m_db = '0; m_gate = 0; m_start = 0; m_idx = '0; m_hp = 0; m_tail_on = 0;
      m_tail_left = 0;
      return;
    end
    sel = '0;
    for (int i = 0; i < 8; i++) if (m_db[i]) sel = 3'(i);
    m_start = 0;
    if (|m_db) begin
      if (!m_gate || m_tail_on || sel != m_idx) m_start = 1;
      m_gate = 1; m_idx = sel; m_hp = hp_tab[sel]; m_tail_on = 0;
    end else if (m_tail_on) begin
      m_tail_left--;
      if (m_tail_left == 0) begin m_tail_on = 0; m_gate = 0; end
    end else if (m_gate) begin
`ifdef KEY_RELEASE_HOLD_EN
      m_tail_on = 1; m_tail_left = HOLD;
`else
      m_gate = 0;
`endif
    end
    // A level is accepted once the synchronised input (raw delayed 2 edges)
    // has disagreed with it for DB consecutive edges.
    new_db = m_db;
    for (int i = 0; i < 8; i++) begin
      all_diff = 1;
      for (int j = 1; j <= DB; j++) if (hist[j][i] == m_db[i]) all_diff = 0;
      if (all_diff) new_db[i] = ~m_db[i];
    end
    m_db = new_db;
    for (int j = 16; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = keys;
  endtask

  initial begin
    for (int j = 0; j < 17; j++) hist[j] = '0;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("keys_db", keys_db, m_db);
      check("half_period", half_period, m_hp);
      check("note_idx", note_idx, m_idx);
      check("note_gate", note_gate, m_gate);
      check("note_start", note_start, m_start);
      if (note_start) starts++;
      if (!note_gate && !reset) gate_low++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_db_zero();
    for (int i = 0; i < 60 && keys_db != 0; i++) @(negedge clk);
    check("keys_db_cleared", keys_db, 0);
  endtask

  logic [63:0] acc;
  int s0, g0, n;

  initial begin
    reset = 1'b1;
    keys  = '0;
    cycles(3);
    check("reset_state", {keys_db, half_period, note_idx, note_gate, note_start}, 0);
    #2 reset = 1'b0;

    acc = '0;
    repeat (100) begin
      @(negedge clk);
      acc |= {keys_db, half_period, note_idx, note_gate, note_start};
    end
    check("idle_after_reset", acc[31:0] | acc[63:32], 0);

    // Single key: debounce latency and first load.
    keys = 8'h20;
    cycles(17);
    check("db_not_yet", keys_db, 0);
    cycles(1);
    check("db_rise_18", keys_db, 8'h20);
    check("gate_before_load", note_gate, 0);
    cycles(1);
    check("load_idx5", note_idx, 5);
    check("load_hp5", half_period, 28409);
    check("load_gate", note_gate, 1);
    check("load_start", note_start, 1);
    cycles(1);
    check("start_one_cycle", note_start, 0);
    cycles(21);
    keys = '0;
    cycles(60);

    // Short glitch is filtered.
    s0 = starts;
    keys = 8'h04;
    cycles(10);
    keys = '0;
    cycles(30);
    check("glitch_db", keys_db, 0);
    check("glitch_gate", note_gate, 0);
    check("glitch_starts", starts - s0, 0);

    // Higher key takes over, release falls back without a gate gap.
    keys = 8'h02;
    cycles(25);
    check("k1_idx", note_idx, 1);
    s0 = starts; g0 = gate_low;
    keys = 8'h42;
    cycles(25);
    check("k6_idx", note_idx, 6);
    check("k6_hp", half_period, 25309);
    check("k6_starts", starts - s0, 1);
    s0 = starts;
    keys = 8'h02;
    cycles(25);
    check("back_k1_idx", note_idx, 1);
    check("back_k1_hp", half_period, 42565);
    check("back_k1_starts", starts - s0, 1);
    check("no_gate_gap", gate_low - g0, 0);

    // Release-all gate latency measured from keys_db reaching 0.
    keys = '0;
    wait_db_zero();
    n = 0;
    do begin @(negedge clk); n++; end while (note_gate && n < 100);
`ifdef KEY_RELEASE_HOLD_EN
    check("release_latency", n, 33);
`else
    check("release_latency", n, 1);
`endif
    cycles(5);

    // Re-press of key 0 right after release.
    keys = 8'h02;
    cycles(25);
    g0 = gate_low;
    keys = '0;
    wait_db_zero();
    keys = 8'h01;
    cycles(22);
    check("repress_idx", note_idx, 0);
    check("repress_hp", half_period, 47778);
`ifdef KEY_RELEASE_HOLD_EN
    check("repress_no_gap", gate_low - g0, 0);
`endif
    keys = '0;
    cycles(60);

    // Reset mid-note: immediate clear, then full re-debounce.
    keys = 8'h08;
    cycles(25);
    check("pre_reset_gate", note_gate, 1);
    #2 reset = 1'b1;
    #1 check("async_reset", {keys_db, half_period, note_idx, note_gate, note_start}, 0);
    cycles(2);
    #2 reset = 1'b0;
    cycles(18);
    check("redebounce_gate_low", note_gate, 0);
    cycles(1);
    check("redebounce_gate_high", note_gate, 1);
    check("redebounce_idx", note_idx, 3);
    keys = '0;
    cycles(60);

    // Randomised phase.
    for (int seg = 0; seg < 60; seg++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        #2 reset = 1'b1;
        cycles(2);
        #2 reset = 1'b0;
      end else begin
        keys = 8'($urandom & $urandom);
        cycles(r < 8 ? $urandom_range(1, 15) : $urandom_range(16, 45));
      end
    end
    keys = '0;
    cycles(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
